// File: rtl/gs232c_jtb_ctl.sv
// gs232c_jtb_ctl: single-port JTB SRAM controller. It arbitrates fetch-side
// lookups against queued retire-side training writes, forwards lookups from
// the training queue, and sweeps the array to invalid after reset.
module gs232c_jtb_ctl #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    input  logic [63:0] lk_path,
    output logic        lk_ready,
    input  logic        lk_kill,
    output logic        lk_rvalid,
    output logic        lk_rhit,
    output logic [31:0] lk_rtarget,
    input  logic        tr_valid,
    input  logic [31:0] tr_pc,
    input  logic [63:0] tr_path,
    input  logic [31:0] tr_target,
    output logic        tr_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [38:0] ram_wdata,
    input  logic [38:0] ram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [7:0]  tag;
        logic [29:0] tgt;
    } entry_t;

    state_t          state;
    logic [7:0]      sc;
    entry_t          q [4];
    logic [1:0]      head;
    logic [1:0]      tail;
    logic [2:0]      count;
    logic [SW-1:0]   starve;
    logic            pend;
    logic [7:0]      pend_tag;
    logic            fwd_hit;
    logic [29:0]     fwd_tgt;

    logic            run;
    logic            forced;
    logic            lk_win;
    logic            wr_issue;
    logic            push;
    logic [7:0]      lk_idx;
    logic [7:0]      lk_tag;
    logic [7:0]      tr_idx;
    logic            m_hit;
    logic [29:0]     m_tgt;
    logic            rd_hit;

    // Index is the PC word bits XORed with all eight path-history bytes.
    function automatic logic [7:0] fold_idx(input logic [31:0] pc, input logic [63:0] path);
        logic [7:0] r;
        r = pc[9:2];
        for (int i = 0; i < 8; i++) begin
            r = r ^ path[i*8 +: 8];
        end
        return r;
    endfunction

    assign run      = (state == RUN) && !reset;
    assign forced   = run && (count != 3'd0) &&
                      ((count == 3'd4) || (starve == SW'(STARVE_MAX)));
    assign lk_ready = run && !forced;
    assign tr_ready = run && (count != 3'd4);
    assign lk_win   = lk_valid && lk_ready;
    assign wr_issue = run && (count != 3'd0) && (forced || !lk_win);
    assign push     = tr_valid && tr_ready;
    assign lk_idx   = fold_idx(lk_pc, lk_path);
    assign lk_tag   = lk_pc[17:10];
    assign tr_idx   = fold_idx(tr_pc, tr_path);

    // Queue search from oldest to youngest so the youngest match wins; the
    // entry being popped this cycle is still present and therefore compared.
    always_comb begin
        logic [1:0] slot;
        m_hit = 1'b0;
        m_tgt = '0;
        slot  = '0;
        for (int i = 0; i < 4; i++) begin
            slot = head + 2'(i);
            if ((3'(i) < count) && (q[slot].idx == lk_idx) && (q[slot].tag == lk_tag)) begin
                m_hit = 1'b1;
                m_tgt = q[slot].tgt;
            end
        end
    end

    // SRAM port mux: sweep in INIT, then write-head or lookup in RUN.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!reset && (state == INIT)) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = sc;
        end else if (wr_issue) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = q[head].idx;
            ram_wdata = {1'b1, q[head].tag, q[head].tgt};
        end else if (lk_win) begin
            ram_en   = 1'b1;
            ram_addr = lk_idx;
        end
    end

    // Response combines the registered forwarding result with the SRAM read.
    always_comb begin
        rd_hit     = ram_rdata[38] && (ram_rdata[37:30] == pend_tag);
        lk_rvalid  = pend && !lk_kill && !reset;
        lk_rhit    = lk_rvalid && (fwd_hit || rd_hit);
        lk_rtarget = '0;
        if (lk_rhit) begin
            lk_rtarget = fwd_hit ? {fwd_tgt, 2'b00} : {ram_rdata[29:0], 2'b00};
        end
    end

    // Control state: FSM, sweep counter, queue pointers, starvation, pending response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= INIT;
            sc     <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            starve <= '0;
            pend   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sc <= sc + 8'd1;
                    if (sc == 8'hFF) state <= RUN;
                end
                default: ;
            endcase
            pend <= lk_win;
            if (wr_issue) head <= head + 2'd1;
            if (push)     tail <= tail + 2'd1;
            case ({push, wr_issue})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
            if (wr_issue) begin
                starve <= '0;
            end else if (run && (count != 3'd0) && lk_win && (starve != SW'(STARVE_MAX))) begin
                starve <= starve + 1'b1;
            end
        end
    end

    // Datapath: queue entries and the lookup's captured tag/forward result.
    always_ff @(posedge clock) begin
        if (push) q[tail] <= '{idx: tr_idx, tag: tr_pc[17:10], tgt: tr_target[31:2]};
        if (lk_win) begin
            pend_tag <= lk_tag;
            fwd_hit  <= m_hit;
            fwd_tgt  <= m_tgt;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lk_pc[31:18], lk_pc[1:0], tr_pc[31:18], tr_pc[1:0], tr_target[1:0]};

endmodule

// File: tb/tb_gs232c_jtb_ctl.sv
// Testbench for gs232c_jtb_ctl: directed sequences, a vector table and
// random traffic, all checked against a transaction-level reference model.
module tb_gs232c_jtb_ctl;
    localparam int MAXS = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = '0;
    logic [63:0] lk_path = '0;
    logic        lk_ready;
    logic        lk_kill = 1'b0;
    logic        lk_rvalid;
    logic        lk_rhit;
    logic [31:0] lk_rtarget;
    logic        tr_valid = 1'b0;
    logic [31:0] tr_pc = '0;
    logic [63:0] tr_path = '0;
    logic [31:0] tr_target = '0;
    logic        tr_ready;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [38:0] ram_wdata;
    logic [38:0] ram_rdata = '0;

    gs232c_jtb_ctl #(.STARVE_MAX(MAXS)) dut (
        .clock(clock), .reset(reset),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_path(lk_path), .lk_ready(lk_ready),
        .lk_kill(lk_kill), .lk_rvalid(lk_rvalid), .lk_rhit(lk_rhit), .lk_rtarget(lk_rtarget),
        .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_path(tr_path), .tr_target(tr_target),
        .tr_ready(tr_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural single-port SRAM seen by the DUT
    logic [38:0] sram [256];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) sram[ram_addr] <= ram_wdata;
            else        ram_rdata <= sram[ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  idx;
        logic [7:0]  tag;
        logic [29:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic [38:0] ref_mem [256];
    bit          m_init  = 1'b1;
    int          m_sc    = 0;
    int          m_starve = 0;
    bit          m_pend  = 1'b0;
    bit          m_ph    = 1'b0;
    logic [31:0] m_pt    = '0;

    function automatic logic [7:0] ref_idx(input logic [31:0] pc, input logic [63:0] path);
        logic [7:0]  r;
        logic [63:0] p;
        r = pc[9:2];
        p = path;
        repeat (8) begin
            r = r ^ p[7:0];
            p = p >> 8;
        end
        return r;
    endfunction

    task automatic settle();
        #3;
    endtask

    // Compare DUT outputs of the current cycle against the model, then step both.
    task automatic advance();
        bit          e_en, e_we, e_lkr, e_trr, e_rv, e_rh;
        logic [7:0]  e_addr;
        logic [38:0] e_wd;
        logic [31:0] e_rt;
        bit          forced, win, wr, hit;
        logic [7:0]  li, lt;
        logic [31:0] ht;
        int          n;
        n = mq.size();
        e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_lkr = 0; e_trr = 0;
        win = 0; wr = 0;
        e_rv = m_pend && !lk_kill && !reset;
        e_rh = e_rv && m_ph;
        e_rt = e_rh ? m_pt : 32'h0;
        if (reset) begin
            // all zero
        end else if (m_init) begin
            e_en = 1; e_we = 1; e_addr = 8'(m_sc);
        end else begin
            forced = (n > 0) && ((n == 4) || (m_starve == MAXS));
            e_lkr  = !forced;
            e_trr  = (n != 4);
            win    = lk_valid && e_lkr;
            wr     = (n > 0) && (forced || !win);
            e_en   = wr || win;
            e_we   = wr;
            if (wr) begin
                e_addr = mq[0].idx;
                e_wd   = {1'b1, mq[0].tag, mq[0].tgt};
            end else begin
                e_addr = ref_idx(lk_pc, lk_path);
            end
        end
        chk("lk_ready", 64'(lk_ready), 64'(e_lkr));
        chk("tr_ready", 64'(tr_ready), 64'(e_trr));
        chk("ram_en", 64'(ram_en), 64'(e_en));
        if (e_en) begin
            chk("ram_we", 64'(ram_we), 64'(e_we));
            chk("ram_addr", 64'(ram_addr), 64'(e_addr));
        end
        if (e_en && e_we) chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
        chk("lk_rvalid", 64'(lk_rvalid), 64'(e_rv));
        chk("lk_rhit", 64'(lk_rhit), 64'(e_rh));
        chk("lk_rtarget", 64'(lk_rtarget), 64'(e_rt));

        if (reset) begin
            m_init = 1; m_sc = 0; mq.delete(); m_starve = 0; m_pend = 0;
        end else if (m_init) begin
            ref_mem[m_sc] = '0;
            m_sc++;
            if (m_sc == 256) m_init = 0;
            m_pend = 0;
        end else begin
            if (win) begin
                li = ref_idx(lk_pc, lk_path);
                lt = lk_pc[17:10];
                hit = 0;
                ht = 32'h0;
                for (int i = n - 1; i >= 0; i--) begin
                    if (!hit && mq[i].idx == li && mq[i].tag == lt) begin
                        hit = 1;
                        ht = {mq[i].tgt, 2'b00};
                    end
                end
                if (!hit && ref_mem[li][38] && ref_mem[li][37:30] == lt) begin
                    hit = 1;
                    ht = {ref_mem[li][29:0], 2'b00};
                end
                m_ph = hit;
                m_pt = ht;
            end
            m_pend = win;
            if (wr) begin
                ref_mem[mq[0].idx] = {1'b1, mq[0].tag, mq[0].tgt};
                void'(mq.pop_front());
                m_starve = 0;
            end else if (win && n > 0 && m_starve < MAXS) begin
                m_starve++;
            end
            if (tr_valid && e_trr)
                mq.push_back('{idx: ref_idx(tr_pc, tr_path), tag: tr_pc[17:10], tgt: tr_target[31:2]});
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle();
        lk_valid = 0; tr_valid = 0; lk_kill = 0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [63:0] path;
        logic [31:0] target;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h1C00_0040, 64'h0,                   32'h1C00_1000, 8'h10};
        vecs[1] = '{32'h0000_0000, 64'h0102_0408_1020_4080, 32'h8000_0004, 8'hFF};
        vecs[2] = '{32'h0000_03FC, 64'h0000_0000_0000_00FF, 32'h1234_5678, 8'h00};
        vecs[3] = '{32'h1234_5678, 64'hAA00_0000_0000_0055, 32'hDEAD_BEEC, 8'h61};
        vecs[4] = '{32'h0000_0104, 64'h1111_1111_1111_1111, 32'h0BAD_F00D, 8'h41};

        @(posedge clock); #1;
        repeat (3) tick();

        // Sweep with lookups held
        reset = 0;
        lk_valid = 1;
        for (int i = 0; i < 256; i++) begin
            settle();
            chk("sweep_lk_ready", 64'(lk_ready), 64'h0);
            chk("sweep_write", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 8'(i), 39'h0}));
            advance();
        end
        settle();
        chk("first_accept", 64'(lk_ready), 64'h1);
        advance();
        lk_valid = 0;
        settle();
        chk("first_resp_valid", 64'(lk_rvalid), 64'h1);
        chk("first_resp_miss", 64'(lk_rhit), 64'h0);
        advance();

        // Train then lookup
        tr_valid = 1; tr_pc = 32'h1C00_0040; tr_path = 0; tr_target = 32'h1C00_1000;
        tick();
        tr_valid = 0;
        settle();
        chk("train_write_addr", 64'({ram_we, ram_addr}), 64'({1'b1, 8'h10}));
        advance();
        tick();
        lk_valid = 1; lk_pc = 32'h1C00_0040; lk_path = 0;
        tick();
        lk_valid = 0;
        settle();
        chk("train_lookup_hit", 64'(lk_rhit), 64'h1);
        chk("train_lookup_tgt", 64'(lk_rtarget), 64'h1C00_1000);
        advance();

        // Forwarding followed by starvation-forced write
        lk_valid = 1; lk_pc = 32'h1C00_0040; lk_path = 0;
        tr_valid = 1; tr_pc = 32'h1C00_0040; tr_path = 0; tr_target = 32'h2C00_3000;
        tick();
        tr_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk("starve_lk_ready", 64'(lk_ready), 64'h1);
            chk("starve_no_write", 64'(ram_we), 64'h0);
            if (k == 1) chk("pre_fwd_old_tgt", 64'(lk_rtarget), 64'h1C00_1000);
            if (k == 2) chk("fwd_tgt", 64'({lk_rhit, lk_rtarget}), 64'({1'b1, 32'h2C00_3000}));
            advance();
        end
        settle();
        chk("starve_forced_ready", 64'(lk_ready), 64'h0);
        chk("starve_forced_write", 64'({ram_we, ram_addr}), 64'({1'b1, 8'h10}));
        advance();
        settle();
        chk("starve_cleared", 64'(lk_ready), 64'h1);
        advance();
        idle();
        tick();

        // Full queue under continuous lookups
        lk_valid = 1; lk_pc = 32'h0000_0800; lk_path = 0;
        for (int j = 0; j < 4; j++) begin
            tr_valid = 1; tr_pc = 32'h2000_0000 + 32'(j * 4); tr_path = 0;
            tr_target = 32'h3000_0000 + 32'(j * 16);
            tick();
        end
        tr_valid = 0;
        settle();
        chk("full_tr_ready", 64'(tr_ready), 64'h0);
        chk("full_lk_ready", 64'(lk_ready), 64'h0);
        chk("full_forced_write", 64'(ram_we), 64'h1);
        advance();
        settle();
        chk("full_after_lk_ready", 64'(lk_ready), 64'h1);
        advance();
        idle();
        repeat (5) tick();

        // Kill
        lk_valid = 1; lk_pc = 32'h1C00_0040; lk_path = 0;
        tick();
        lk_valid = 0; lk_kill = 1;
        settle();
        chk("kill_no_rvalid", 64'({lk_rvalid, lk_rhit}), 64'h0);
        advance();
        lk_kill = 0;
        settle();
        chk("kill_after", 64'(lk_rvalid), 64'h0);
        advance();

        // Vector table: index folding, write, then lookup
        for (int v = 0; v < 5; v++) begin
            tr_valid = 1; tr_pc = vecs[v].pc; tr_path = vecs[v].path; tr_target = vecs[v].target;
            tick();
            tr_valid = 0;
            settle();
            chk($sformatf("vec%0d_waddr", v), 64'({ram_we, ram_addr}), 64'({1'b1, vecs[v].exp_addr}));
            advance();
            tick();
            lk_valid = 1; lk_pc = vecs[v].pc; lk_path = vecs[v].path;
            tick();
            lk_valid = 0;
            settle();
            chk($sformatf("vec%0d_hit", v), 64'({lk_rhit, lk_rtarget}),
                64'({1'b1, vecs[v].target[31:2], 2'b00}));
            advance();
        end

        // Reset in RUN with queued writes and a pending lookup, then mid-sweep
        lk_valid = 1; lk_pc = 32'h1C00_0040;
        tr_valid = 1; tr_pc = 32'h2000_0100; tr_target = 32'h4000_0000;
        tick();
        tr_pc = 32'h2000_0200;
        tick();
        idle();
        reset = 1;
        settle();
        chk("reset_kills_resp", 64'({lk_rvalid, ram_en}), 64'h0);
        advance();
        reset = 0;
        for (int i = 0; i < 100; i++) tick();
        reset = 1;
        settle();
        chk("reset_sc100_ram_en", 64'(ram_en), 64'h0);
        advance();
        reset = 0;
        settle();
        chk("sweep_restart_addr0", 64'({ram_we, ram_addr}), 64'({1'b1, 8'h00}));
        advance();
        repeat (255) tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("queue_empty_after_reset", 64'({ram_en, tr_ready}), 64'h1);
            advance();
        end

        // Random traffic against the model
        for (int r = 0; r < 3000; r++) begin
            reset    = ($urandom_range(0, 999) == 0);
            lk_valid = ($urandom_range(0, 9) < 6);
            lk_kill  = ($urandom_range(0, 9) == 0);
            tr_valid = ($urandom_range(0, 9) < 4);
            lk_pc    = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 10);
            tr_pc    = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 10);
            case ($urandom_range(0, 2))
                0:       lk_path = 64'h0;
                1:       lk_path = 64'h0101_0101_0101_0101;
                default: lk_path = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 2))
                0:       tr_path = 64'h0;
                1:       tr_path = 64'h0101_0101_0101_0101;
                default: tr_path = {$urandom, $urandom};
            endcase
            tr_target = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
